// File: rtl/demorgan_checker.sv
// -----------------------------------------------------------------------------
// demorgan_checker
//   Stimulus generator and response checker for the De Morgan gate cell.
//   It steps the cell's A/B inputs through 00, 01, 10, 11. Each vector is
//   held for SETTLE cycles and then sampled for one cycle. The cell's nA,
//   nB and gate output are compared against the form selected at start:
//   AND form (~A)&(~B) or OR form (~A)|(~B). The full sweep is repeated
//   PASSES times. The block then reports pass/fail, a saturating mismatch
//   count and the first failing vector.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             single-cycle run request (ignored unless idle)
//   mode              expected form, 0 = AND, 1 = OR; latched on start
//   drv_a, drv_b      registered stimulus to the cell's A/B inputs
//   obs_na, obs_nb    cell nA / nB outputs
//   obs_out           cell gate output
//   busy              run in progress
//   done              one-cycle pulse at end of run
//   pass              last run had no mismatches
//   err_count         mismatching vectors in last run, saturating
//   first_fail_valid  at least one mismatch in last run
//   first_fail_vec    {A,B} of the first mismatching vector
// -----------------------------------------------------------------------------
module demorgan_checker #(
    parameter int SETTLE = 2,   // 1..15
    parameter int PASSES = 1,   // 1..255
    parameter int ERR_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    output logic             drv_a,
    output logic             drv_b,
    input  logic             obs_na,
    input  logic             obs_nb,
    input  logic             obs_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [1:0]       first_fail_vec
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic       modeLat;
    logic [1:0] vec;
    logic [7:0] passCnt;
    logic [3:0] settleCnt;

    logic expOut;
    logic mismatch;

    // In SAMPLE the drives equal vec, so the expected response comes
    // straight from vec. All three observations fold into a single
    // per-vector mismatch.
    always_comb begin
        expOut   = modeLat ? (~vec[1] | ~vec[0]) : (~vec[1] & ~vec[0]);
        mismatch = (obs_na != ~vec[1]) || (obs_nb != ~vec[0]) || (obs_out != expOut);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            modeLat          <= 1'b0;
            vec              <= 2'b00;
            passCnt          <= 8'd0;
            settleCnt        <= 4'd0;
            drv_a            <= 1'b0;
            drv_b            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        modeLat          <= mode;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= 2'b00;
                        pass             <= 1'b0;
                        vec              <= 2'b00;
                        passCnt          <= 8'd0;
                        settleCnt        <= 4'd0;
                        drv_a            <= 1'b0;
                        drv_b            <= 1'b0;
                        busy             <= 1'b1;
                        state            <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settleCnt == SETTLE_LAST) begin
                        settleCnt <= 4'd0;
                        state     <= SAMPLE;
                    end else begin
                        settleCnt <= settleCnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (!(&err_count)) err_count <= err_count + ERR_ONE;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= vec;
                        end
                    end
                    if (vec != 2'b11) begin
                        vec            <= vec + 2'd1;
                        {drv_a, drv_b} <= vec + 2'd1;
                        state          <= DRIVE;
                    end else if (passCnt != PASS_LAST) begin
                        vec            <= 2'b00;
                        {drv_a, drv_b} <= 2'b00;
                        passCnt        <= passCnt + 8'd1;
                        state          <= DRIVE;
                    end else begin
                        {drv_a, drv_b} <= 2'b00;
                        state          <= FINISH;
                    end
                end
                FINISH: begin
                    // The last sample has already updated first_fail_valid.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= ~first_fail_valid;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demorgan_checker.sv
module tb_demorgan_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // index 0: default parameters, index 1: SETTLE=2, PASSES=4, ERR_W=2
    logic [1:0] start, mode, drvA, drvB, obsNa, obsNb, obsOut;
    logic [1:0] busy, done, pass, ffv;
    logic [1:0] ffVec0, ffVec1;
    logic [3:0] err0;
    logic [1:0] err1;

    // behavioural cell with fault knobs
    logic [1:0] naStuck, outInv, cellOr;

    int nCmp = 0;
    int nFail = 0;

    always_comb begin
        obsNa  = '0;
        obsNb  = '0;
        obsOut = '0;
        for (int i = 0; i < 2; i++) begin
            obsNa[i]  = naStuck[i] ? 1'b0 : ~drvA[i];
            obsNb[i]  = ~drvB[i];
            obsOut[i] = (cellOr[i] ? (~drvA[i] | ~drvB[i]) : (~drvA[i] & ~drvB[i])) ^ outInv[i];
        end
    end

    demorgan_checker u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]),
        .drv_a(drvA[0]), .drv_b(drvB[0]),
        .obs_na(obsNa[0]), .obs_nb(obsNb[0]), .obs_out(obsOut[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err0),
        .first_fail_valid(ffv[0]), .first_fail_vec(ffVec0)
    );

    demorgan_checker #(.SETTLE(2), .PASSES(4), .ERR_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]),
        .drv_a(drvA[1]), .drv_b(drvB[1]),
        .obs_na(obsNa[1]), .obs_nb(obsNb[1]), .obs_out(obsOut[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err1),
        .first_fail_valid(ffv[1]), .first_fail_vec(ffVec1)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] errOf(input int d);
        return (d == 0) ? {4'b0, err0} : {6'b0, err1};
    endfunction

    function automatic logic [7:0] ffVecOf(input int d);
        return (d == 0) ? {6'b0, ffVec0} : {6'b0, ffVec1};
    endfunction

    // response of the bench's own cell model for one input pair: {nA,nB,out}
    function automatic logic [2:0] cellResp(input int d, input logic a, input logic b);
        logic o;
        o = (cellOr[d] ? (~a | ~b) : (~a & ~b)) ^ outInv[d];
        return {naStuck[d] ? 1'b0 : ~a, ~b, o};
    endfunction

    task automatic checkZero(input int d, input string tag);
        check({tag, ".drv"},  8'({drvA[d], drvB[d]}), 8'd0);
        check({tag, ".busy"}, 8'(busy[d]), 8'd0);
        check({tag, ".done"}, 8'(done[d]), 8'd0);
        check({tag, ".pass"}, 8'(pass[d]), 8'd0);
        check({tag, ".err"},  errOf(d), 8'd0);
        check({tag, ".ffv"},  8'(ffv[d]), 8'd0);
        check({tag, ".ffvec"}, ffVecOf(d), 8'd0);
    endtask

    // One complete run on checker d, checked cycle by cycle against a
    // model built from the sweep rules. Cycle k is the interval after
    // the k-th rising edge, counted from the edge that samples start.
    task automatic runSweep(input int d, input logic m, input int passes, input int settle,
                            input int errMax, input bit glitch, input string tag);
        int total;
        int expErr;
        bit expFf;
        logic [1:0] expVec;
        logic [1:0] vv;
        logic [2:0] ideal;
        logic [1:0] expDrv;
        total  = passes * 4 * (settle + 1);
        expErr = 0;
        expFf  = 1'b0;
        expVec = 2'b00;
        for (int p = 0; p < passes; p++) begin
            for (int v = 0; v < 4; v++) begin
                vv    = 2'(v);
                ideal = {~vv[1], ~vv[0], m ? (~vv[1] | ~vv[0]) : (~vv[1] & ~vv[0])};
                if (cellResp(d, vv[1], vv[0]) !== ideal) begin
                    if (expErr < errMax) expErr++;
                    if (!expFf) begin
                        expFf  = 1'b1;
                        expVec = vv;
                    end
                end
            end
        end

        @(negedge clk);
        start[d] = 1'b1;
        mode[d]  = m;
        for (int k = 0; k <= total + 1; k++) begin
            @(posedge clk);
            #1;
            start[d] = 1'b0;
            expDrv = (k < total) ? 2'((k / (settle + 1)) % 4) : 2'b00;
            check({tag, ".drv"},  8'({drvA[d], drvB[d]}), 8'(expDrv));
            check({tag, ".busy"}, 8'(busy[d]), 8'(k <= total));
            check({tag, ".done"}, 8'(done[d]), 8'(k == total + 1));
            if (k == 0) begin
                check({tag, ".clrErr"}, errOf(d), 8'd0);
                check({tag, ".clrFfv"}, 8'(ffv[d]), 8'd0);
                check({tag, ".clrPass"}, 8'(pass[d]), 8'd0);
            end
            // start and mode wiggles while the run is active must be ignored
            if (glitch && k <= total) begin
                start[d] = (k == 4 || k == 12 || $urandom_range(0, 3) == 0);
                mode[d]  = 1'($urandom);
            end
        end
        start[d] = 1'b0;
        mode[d]  = m;
        for (int h = 0; h < 2; h++) begin
            check({tag, ".pass"},  8'(pass[d]), 8'(expErr == 0));
            check({tag, ".err"},   errOf(d), 8'(expErr));
            check({tag, ".ffv"},   8'(ffv[d]), 8'(expFf));
            check({tag, ".ffvec"}, ffVecOf(d), 8'(expVec));
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        start   = '0;
        mode    = '0;
        naStuck = '0;
        outInv  = '0;
        cellOr  = '0;

        repeat (2) @(posedge clk);
        #1;
        checkZero(0, "rst0");
        checkZero(1, "rst1");
        @(negedge clk);
        rst_n = 1'b1;

        // ideal AND-form cell, AND expectation
        runSweep(0, 1'b0, 1, 2, 15, 1'b0, "andOk");
        // AND-form cell checked as OR form: vectors 01 and 10 fail
        runSweep(0, 1'b1, 1, 2, 15, 1'b0, "andAsOr");
        // nA stuck at 0: vectors 00 and 01 fail
        naStuck[0] = 1'b1;
        runSweep(0, 1'b0, 1, 2, 15, 1'b0, "naStuck");
        naStuck[0] = 1'b0;
        // inverted gate output over four sweeps: counter saturates at 3
        outInv[1] = 1'b1;
        runSweep(1, 1'b0, 4, 2, 3, 1'b0, "satur");
        outInv[1] = 1'b0;

        // reset during the second vector aborts the run with no done pulse
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkZero(0, "midRst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            check("midRst.noDone", 8'(done[0]), 8'd0);
            check("midRst.idle", 8'(busy[0]), 8'd0);
        end
        runSweep(0, 1'b0, 1, 2, 15, 1'b0, "afterRst");

        // restarts and mode changes during a run
        runSweep(0, 1'b0, 1, 2, 15, 1'b1, "reStart");

        // randomised cells, modes and glitching
        for (int r = 0; r < 8; r++) begin
            int d;
            logic m;
            d = int'($urandom_range(0, 1));
            m = 1'($urandom);
            naStuck[d] = ($urandom_range(0, 3) == 0);
            outInv[d]  = ($urandom_range(0, 3) == 0);
            cellOr[d]  = 1'($urandom);
            runSweep(d, m, (d == 0) ? 1 : 4, 2, (d == 0) ? 15 : 3, 1'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/demorgan_checker.md
Name: demorgan_checker

Overview:
- Sequential stimulus generator and response checker for the De Morgan gate cell.
- Drives the cell's A/B inputs through all four input combinations, waits a settle time, then samples nA, nB and the gate output.
- Compares the samples against the expected values for the selected form: AND form (~A)&(~B), or OR form (~A)|(~B).
- Reports pass/fail, a mismatch count and the first failing vector. Sits in the lab bench/self-test wrapper around the gate cell.

Parameters:
- SETTLE, 2, cycles the stimulus is held before sampling (legal range 1..15).
- PASSES, 1, number of full 4-vector sweeps per run (legal range 1..255).
- ERR_W, 4, width of the mismatch counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle run request
- mode  in  1  expected form: 0 = AND form, 1 = OR form; latched on the accepted start
- drv_a  out  1  stimulus to the cell's A input
- drv_b  out  1  stimulus to the cell's B input
- obs_na  in  1  cell's nA output
- obs_nb  in  1  cell's nB output
- obs_out  in  1  cell's gate output
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  result of last run: 1 = no mismatches; held until the next accepted start
- err_count  out  ERR_W  mismatching vectors in the last run; saturates at all-ones
- first_fail_valid  out  1  at least one mismatch occurred in the last run
- first_fail_vec  out  2  {A,B} of the first mismatching vector

Behaviour:
- Reset (async assert, sync deassert by the clock edge): FSM to IDLE. All outputs 0: drv_a, drv_b, busy, done, pass, err_count, first_fail_valid, first_fail_vec. Internal counters 0.
- States: IDLE, DRIVE, SAMPLE, FINISH.
- Vector index vec[1:0] runs 00, 01, 10, 11. drv_a = vec[1], drv_b = vec[0], both registered. Drives are 0 in IDLE and FINISH.
- IDLE:
  - On start=1: latch mode; clear err_count, first_fail_valid, first_fail_vec, pass; vec = 0; pass counter = 0; settle counter = 0; go to DRIVE.
  - busy rises on the cycle after start is sampled.
- DRIVE:
  - Hold drives and increment the settle counter.
  - After SETTLE cycles in DRIVE, go to SAMPLE.
- SAMPLE (one cycle), at the clock edge:
  - Compare obs_na vs ~A, obs_nb vs ~B, obs_out vs (mode ? ~A|~B : ~A&~B).
  - Any difference counts as one mismatch for this vector.
  - On a mismatch, err_count increments unless it is already all-ones.
  - On a mismatch with first_fail_valid=0: set first_fail_valid=1 and first_fail_vec=vec.
- After SAMPLE:
  - If vec != 11: vec+1, go to DRIVE.
  - Else if the pass counter != PASSES-1: vec wraps to 00, pass counter +1, go to DRIVE.
  - Else go to FINISH.
- FINISH (one cycle): done=1, busy=0, pass = (no mismatch this run), then IDLE.
- Latency: each vector takes SETTLE+1 cycles. done asserts PASSES*4*(SETTLE+1)+1 cycles after the cycle start is sampled.
- start while busy or in FINISH is ignored; it is not queued.
- mode changes while busy are ignored.
- Results (pass, err_count, first_fail_*) hold stable in IDLE until the next accepted start.
- rst_n low mid-run aborts immediately to the reset state. No done pulse is produced.
- Obs inputs are sampled only in SAMPLE. Glitches during DRIVE are irrelevant.

Test Plan:
- Ideal AND-form cell, mode=0, SETTLE=2, PASSES=1, start pulse -> drives step 00,01,10,11 for 3 cycles each; done at cycle 13; pass=1, err_count=0, first_fail_valid=0.
- AND-form cell with mode=1 -> vectors 01 and 10 mismatch; err_count=2, first_fail_vec=01, first_fail_valid=1, pass=0.
- obs_na stuck at 0, mode=0 -> vectors 00 and 01 fail; err_count=2, first_fail_vec=00, pass=0.
- ERR_W=2, PASSES=4, obs_out inverted -> 16 mismatches; err_count saturates at 3; done at cycle 4*4*3+1=49.
- rst_n pulsed low during the 2nd vector -> all outputs 0 immediately, no done pulse. A subsequent start runs a clean full sweep with pass=1.
- start re-pulsed at cycles 4 and 12 during a run -> ignored, done still at cycle 13. A new start after done clears the previous results.
